// File: rtl/timer_display_scan.sv
// Three-digit M.SS multiplexed 7-segment driver for the music player timer.
// Optional paused-blink feature: define TIMER_DISPLAY_BLINK_EN.
module timer_display_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int GAP_CYCLES   = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] seconds0,
   input  logic [3:0] seconds1,
   input  logic [3:0] minutes0,
   input  logic       count,
   output logic [2:0] digit_en,
   output logic [6:0] segments,
   output logic       dp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] GAP_PRE  = DIV_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_MIN, S_SEC1, S_SEC0} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [DIV_W-1:0] div;
   logic [3:0]       snap_min;
   logic [3:0]       snap_sec1;
   logic [3:0]       snap_sec0;
   logic [3:0]       digit_nxt;
   logic             slot_end;
   logic             frame_end;
   logic             vis;

   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

   function automatic logic [2:0] anode(input state_t s);
      case (s)
         S_MIN:   anode = 3'b011;
         S_SEC1:  anode = 3'b101;
         S_SEC0:  anode = 3'b110;
         default: anode = 3'b111;
      endcase
   endfunction

   // The slot about to be shown; at frame end minutes come straight from the
   // inputs because the snapshot registers load on that same edge.
   always_comb begin
      slot_end  = (div == DIV_LAST);
      frame_end = slot_end && (state == S_SEC0);
      state_nxt = state;
      digit_nxt = snap_min;
      if (slot_end) begin
         case (state)
            S_MIN:   begin state_nxt = S_SEC1; digit_nxt = snap_sec1; end
            S_SEC1:  begin state_nxt = S_SEC0; digit_nxt = snap_sec0; end
            default: begin state_nxt = S_MIN;  digit_nxt = minutes0;  end
         endcase
      end else begin
         case (state)
            S_MIN:   digit_nxt = snap_min;
            S_SEC1:  digit_nxt = snap_sec1;
            default: digit_nxt = snap_sec0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_MIN;
         div       <= '0;
         snap_min  <= '0;
         snap_sec1 <= '0;
         snap_sec0 <= '0;
         digit_en  <= 3'b111;
         segments  <= 7'b1111111;
         dp        <= 1'b1;
      end else begin
         state    <= state_nxt;
         div      <= slot_end ? '0 : div + 1'b1;
         segments <= seg_decode(digit_nxt);
         dp       <= (state_nxt != S_MIN);
         if (frame_end) begin
            snap_min  <= minutes0;
            snap_sec1 <= seconds1;
            snap_sec0 <= seconds0;
         end
         // Anodes only switch on at the gap end, so a late visibility change waits a slot.
         if (slot_end)
            digit_en <= 3'b111;
         else if (div == GAP_PRE && vis)
            digit_en <= anode(state);
      end
   end

`ifdef TIMER_DISPLAY_BLINK_EN
   localparam int FC_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   logic [FC_W-1:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         vis       <= 1'b1;
      end else if (count) begin
         frame_cnt <= '0;
         vis       <= 1'b1;
      end else if (frame_end) begin
         if (frame_cnt == FC_LAST) begin
            frame_cnt <= '0;
            vis       <= ~vis;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end
`else
   // Without blink the display is always visible; count has no effect.
   assign vis = count | 1'b1;
`endif

endmodule

// File: tb/tb_timer_display_scan.sv
// Scoreboard bench for timer_display_scan: per-cycle expectations from a slot/frame model.
module tb_timer_display_scan;

   localparam int SD  = 8;
   localparam int GAP = 2;
   localparam int BF  = 2;
   localparam int FR  = 3 * SD;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] seconds0;
   logic [3:0] seconds1;
   logic [3:0] minutes0;
   logic       count;
   logic [2:0] digit_en;
   logic [6:0] segments;
   logic       dp;

   timer_display_scan #(.SCAN_DIV(SD), .GAP_CYCLES(GAP), .BLINK_FRAMES(BF)) dut (
      .clk      (clk),
      .reset    (reset),
      .seconds0 (seconds0),
      .seconds1 (seconds1),
      .minutes0 (minutes0),
      .count    (count),
      .digit_en (digit_en),
      .segments (segments),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         k;
      logic [2:0] en;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference model state: cycles since reset, frame snapshot, visibility.
   int         k;
   logic [3:0] sm, s1, s0;
   logic [2:0] en_m;
   logic       vis_m;
   int         fc_m;

   task automatic cyc();
      exp_t       e;
      int         dv;
      int         sl;
      logic [2:0] an;
      @(posedge clk);
      if (reset) begin
         k = 0; sm = 0; s1 = 0; s0 = 0;
         en_m = 3'b111; vis_m = 1'b1; fc_m = 0;
         e.seg = 7'b1111111; e.dp = 1'b1;
      end else begin
         k++;
         dv = k % SD;
         sl = (k / SD) % 3;
         an = 3'b100 >> sl;
         if (dv == 0) en_m = 3'b111;
         else if (dv == GAP && vis_m) en_m = ~an;
`ifdef TIMER_DISPLAY_BLINK_EN
         if (count) begin
            fc_m = 0; vis_m = 1'b1;
         end else if (k % FR == 0) begin
            if (fc_m == BF - 1) begin fc_m = 0; vis_m = !vis_m; end
            else fc_m++;
         end
`endif
         if (k % FR == 0) begin
            sm = minutes0; s1 = seconds1; s0 = seconds0;
         end
         e.seg = seg_tab[(sl == 0) ? sm : (sl == 1) ? s1 : s0];
         e.dp  = (sl != 0);
      end
      e.k  = k;
      e.en = en_m;
      sb.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk($sformatf("digit_en@k%0d", mon_e.k), 32'(digit_en), 32'(mon_e.en));
         chk($sformatf("segments@k%0d", mon_e.k), 32'(segments), 32'(mon_e.seg));
         chk($sformatf("dp@k%0d", mon_e.k), 32'(dp), 32'(mon_e.dp));
         chk($sformatf("one_anode@k%0d", mon_e.k), 32'($countones(~digit_en) <= 1), 32'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; count = 1'b0;
      minutes0 = 4'd1; seconds1 = 4'd5; seconds0 = 4'd9;
      cyc(); cyc();
      reset = 1'b0;
      // Frame 0 shows 0.00, frame 1 shows 1.59; change mid S_SEC1 of frame 1.
      while (k < FR + SD + 4) cyc();
      minutes0 = 4'd2; seconds1 = 4'd0; seconds0 = 4'd0;
      while (k < 60) cyc();
      seconds0 = 4'hC;
      while (k < 84) cyc();
      seconds0 = 4'd3;
      // Frames 4-5 visible again; frame 6 blanked until count rises.
      while (k < 150) cyc();
      count = 1'b1;
      while (k < 170) cyc();
      count = 1'b0;
      while (k % FR != SD + 5) cyc();
      reset = 1'b1;
      minutes0 = 4'd7; seconds1 = 4'd3; seconds0 = 4'd8;
      cyc();
      reset = 1'b0;
      while (k < 2 * FR + 12) cyc();
      @(negedge clk);
      #1;
      chk("drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
